// File: rtl/toast_pkg.sv
// ============================================================================
// Module  : toast_pkg
// Purpose : Shared definitions for the Toast integer register file. This
//           package holds the clear/run FSM state encoding, the default
//           geometry, and a port-slicing helper for the packed per-port buses.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package toast_pkg;

  // Clear/run FSM encoding.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // Default geometry.
  localparam int unsigned RF_DATA_W_DEF = 32;
  localparam int unsigned RF_ADDR_W_DEF = 5;
  localparam int unsigned RF_DEPTH_DEF  = 32;
  localparam int unsigned RF_NUM_RD_DEF = 2;
  localparam int unsigned RF_NUM_WR_DEF = 1;

  // Returns the LSB position of port PORT within a packed bus whose per-port
  // width is WIDTH.
  function automatic int unsigned rf_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/toast_regfile_bypass.sv
// ============================================================================
// Module  : toast_regfile_bypass
// Purpose : Read-port result selection for one read port. It forwards the
//           write data from the current cycle when a write targets the same
//           address, and otherwise passes through the array read data.
//           Address 0 and every read outside RUN return 0.
// Ports   : rs_addr_i  - read address of this port
//           wr_addr_i  - packed write addresses (NUM_WR ports)
//           wr_data_i  - packed write data
//           wr_en_i    - per-write-port enable
//           run_i      - file is in RUN state
//           arr_data_i - array read data, already 0 for out-of-range
//           rs_data_o  - final read data
//           hit_o      - this read was served from the bypass path
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module toast_regfile_bypass
  import toast_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH     = RF_DATA_W_DEF,
  parameter int unsigned REGFILE_ADDR_WIDTH = RF_ADDR_W_DEF,
  parameter int unsigned REGFILE_DEPTH      = RF_DEPTH_DEF,
  parameter int unsigned NUM_WR             = RF_NUM_WR_DEF
) (
  input  logic [REGFILE_ADDR_WIDTH-1:0]        rs_addr_i,
  input  logic [NUM_WR*REGFILE_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR*REG_DATA_WIDTH-1:0]     wr_data_i,
  input  logic [NUM_WR-1:0]                    wr_en_i,
  input  logic                                 run_i,
  input  logic [REG_DATA_WIDTH-1:0]            arr_data_i,
  output logic [REG_DATA_WIDTH-1:0]            rs_data_o,
  output logic                                 hit_o
);

  localparam int unsigned AW = REGFILE_ADDR_WIDTH;
  localparam int unsigned DW = REG_DATA_WIDTH;

  logic          w_valid_addr;
  logic          w_hit;
  logic [DW-1:0] w_byp_data;

  // Out-of-range addresses are never stored, so they are not forwarded either.
  assign w_valid_addr = (rs_addr_i != '0) && (int'(rs_addr_i) < int'(REGFILE_DEPTH));

  // Ascending scan: the last match (highest write port) wins, matching the
  // write-collision priority of the array.
  always_comb begin
    w_hit      = 1'b0;
    w_byp_data = '0;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (wr_en_i[j] && (wr_addr_i[rf_lsb(j, AW) +: AW] == rs_addr_i)) begin
        w_hit      = 1'b1;
        w_byp_data = wr_data_i[rf_lsb(j, DW) +: DW];
      end
    end
  end

  always_comb begin
    rs_data_o = '0;
    hit_o     = 1'b0;
    if (run_i && w_valid_addr) begin
      if (w_hit) begin
        rs_data_o = w_byp_data;
        hit_o     = 1'b1;
      end else begin
        rs_data_o = arr_data_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/toast_regfile_mp.sv
// ============================================================================
// Module  : toast_regfile_mp
// Purpose : Multi-port integer register file with write-to-read bypass and a
//           hardware clear engine. Storage entries have no per-entry reset.
//           After reset, or when clear_req_i is pulsed, entries 1..DEPTH-1
//           are zeroed one per cycle.
// Ports   : clk_i, reset_i (sync, active-high), clear_req_i, ready_o,
//           rs_addr_i/rs_data_o  (NUM_RD packed read ports),
//           rd_addr_i/rd_wr_data_i/rd_wr_en_i (NUM_WR packed write ports),
//           parity_err_o (per read port)
// Config  : TOAST_REGFILE_PARITY_EN - store an even-parity bit per entry and
//           flag mismatches on array reads. When it is undefined,
//           parity_err_o is tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module toast_regfile_mp
  import toast_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH     = RF_DATA_W_DEF,
  parameter int unsigned REGFILE_ADDR_WIDTH = RF_ADDR_W_DEF,
  parameter int unsigned REGFILE_DEPTH      = RF_DEPTH_DEF,
  parameter int unsigned NUM_RD             = RF_NUM_RD_DEF,
  parameter int unsigned NUM_WR             = RF_NUM_WR_DEF
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 clear_req_i,
  output logic                                 ready_o,
  input  logic [NUM_RD*REGFILE_ADDR_WIDTH-1:0] rs_addr_i,
  output logic [NUM_RD*REG_DATA_WIDTH-1:0]     rs_data_o,
  input  logic [NUM_WR*REGFILE_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [NUM_WR*REG_DATA_WIDTH-1:0]     rd_wr_data_i,
  input  logic [NUM_WR-1:0]                    rd_wr_en_i,
  output logic [NUM_RD-1:0]                    parity_err_o
);

  localparam int unsigned AW = REGFILE_ADDR_WIDTH;
  localparam int unsigned DW = REG_DATA_WIDTH;
  localparam int          DEPTH = int'(REGFILE_DEPTH);
  localparam logic [AW-1:0] LAST_C = AW'(REGFILE_DEPTH - 1);

  rf_state_e     state_q;
  logic [AW-1:0] clr_ptr_q;
  logic          w_run;

  // Entry 0 is hardwired to zero, so no storage exists for it.
  logic [DW-1:0] mem_q       [1:DEPTH-1];
  logic          ent_we_d    [1:DEPTH-1];
  logic [DW-1:0] ent_wdata_d [1:DEPTH-1];

  assign w_run   = (state_q == RF_RUN);
  assign ready_o = w_run;

  // Clear/run FSM. reset_i dominates. In CLEAR, clr_ptr walks 1..DEPTH-1 and
  // the cycle that writes the last entry moves the FSM to RUN.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= AW'(1);
    end else if (state_q == RF_CLEAR) begin
      clr_ptr_q <= clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_C) begin
        state_q <= RF_RUN;
      end
    end else if (clear_req_i) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= AW'(1);
    end
  end

  // Per-entry write decode. Addresses 0 and >= DEPTH match no entry, so those
  // writes are dropped. Later ports override earlier ports on a collision.
  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      ent_we_d[i]    = 1'b0;
      ent_wdata_d[i] = '0;
      if (!reset_i) begin
        if (!w_run) begin
          ent_we_d[i] = (clr_ptr_q == AW'(i));
        end else begin
          for (int j = 0; j < int'(NUM_WR); j++) begin
            if (rd_wr_en_i[j] && (rd_addr_i[rf_lsb(j, AW) +: AW] == AW'(i))) begin
              ent_we_d[i]    = 1'b1;
              ent_wdata_d[i] = rd_wr_data_i[rf_lsb(j, DW) +: DW];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (ent_we_d[i]) begin
        mem_q[i] <= ent_wdata_d[i];
      end
    end
  end

`ifdef TOAST_REGFILE_PARITY_EN
  logic par_q [1:DEPTH-1];

  // Write data is 0 during clear, so cleared entries hold parity 0.
  always_ff @(posedge clk_i) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (ent_we_d[i]) begin
        par_q[i] <= ^ent_wdata_d[i];
      end
    end
  end
`endif

  generate
    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_arr_data;
      logic          w_arr_bad;
      logic          w_hit;

      assign w_addr = rs_addr_i[k*AW +: AW];

      // Array read mux. An address with no matching entry reads 0.
      always_comb begin
        w_arr_data = '0;
        w_arr_bad  = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
          if (w_addr == AW'(i)) begin
            w_arr_data = mem_q[i];
`ifdef TOAST_REGFILE_PARITY_EN
            w_arr_bad  = par_q[i] ^ (^mem_q[i]);
`endif
          end
        end
      end

      toast_regfile_bypass #(
        .REG_DATA_WIDTH     (REG_DATA_WIDTH),
        .REGFILE_ADDR_WIDTH (REGFILE_ADDR_WIDTH),
        .REGFILE_DEPTH      (REGFILE_DEPTH),
        .NUM_WR             (NUM_WR)
      ) u_bypass (
        .rs_addr_i  (w_addr),
        .wr_addr_i  (rd_addr_i),
        .wr_data_i  (rd_wr_data_i),
        .wr_en_i    (rd_wr_en_i),
        .run_i      (w_run),
        .arr_data_i (w_arr_data),
        .rs_data_o  (rs_data_o[k*DW +: DW]),
        .hit_o      (w_hit)
      );

      // A parity error is reported only for a real array read in RUN. The
      // array mux already returns "no error" for address 0 and out-of-range
      // addresses.
      assign parity_err_o[k] = w_run && !w_hit && w_arr_bad;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_toast_regfile_mp.sv
// ============================================================================
// Module  : tb_toast_regfile_mp
// Purpose : Self-checking bench for toast_regfile_mp (2 read / 2 write ports).
//           A reference model computes the expected ready/read/parity values,
//           pushes them to a scoreboard, and compares them against the DUT
//           between clock edges.
// Config  : TOAST_REGFILE_PARITY_EN adds the backdoor parity-corruption case.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toast_regfile_mp;
  import toast_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic               clk = 1'b0;
  logic               reset_i = 1'b0;
  logic               clear_req_i = 1'b0;
  logic               ready_o;
  logic [NRD*AW-1:0]  rs_addr = '0;
  logic [NRD*DW-1:0]  rs_data;
  logic [NWR*AW-1:0]  wa = '0;
  logic [NWR*DW-1:0]  wd = '0;
  logic [NWR-1:0]     we = '0;
  logic [NRD-1:0]     perr;

  always #5 clk = ~clk;

  toast_regfile_mp #(
    .REG_DATA_WIDTH     (DW),
    .REGFILE_ADDR_WIDTH (AW),
    .REGFILE_DEPTH      (DEPTH),
    .NUM_RD             (NRD),
    .NUM_WR             (NWR)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .clear_req_i  (clear_req_i),
    .ready_o      (ready_o),
    .rs_addr_i    (rs_addr),
    .rs_data_o    (rs_data),
    .rd_addr_i    (wa),
    .rd_wr_data_i (wd),
    .rd_wr_en_i   (we),
    .parity_err_o (perr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_bad [DEPTH];
  bit            m_run;
  int            m_ptr;

  typedef struct {
    string       tag;
    int          sel;   // 0 = ready, 1..NRD = read data, NRD+1.. = parity error
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    if (sel == 0) return {31'b0, ready_o};
    if (sel <= NRD) return rs_data[(sel-1)*DW +: DW];
    return {31'b0, perr[sel-1-NRD]};
  endfunction

  task automatic set_rd(input int k, input int addr);
    rs_addr[k*AW +: AW] = AW'(addr);
  endtask

  task automatic set_wr(input int j, input bit en, input int addr, input logic [DW-1:0] data);
    we[j]            = en;
    wa[j*AW +: AW]   = AW'(addr);
    wd[j*DW +: DW]   = data;
  endtask

  task automatic no_wr();
    we = '0;
  endtask

  // Expected read result for port k under the current inputs and model state.
  task automatic exp_read(input int k, output logic [DW-1:0] d, output bit pe);
    logic [AW-1:0] a;
    bit hit;
    a = rs_addr[k*AW +: AW];
    d = '0; pe = 1'b0; hit = 1'b0;
    if (m_run && a != 0) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && wa[j*AW +: AW] == a) begin
          hit = 1'b1;
          d = wd[j*DW +: DW];
        end
      end
      if (!hit) begin
        d  = m_mem[a];
        pe = m_bad[a];
      end
    end
  endtask

  // One clock cycle: push expectations, compare at negedge, then advance the
  // model on the rising edge with the inputs that were applied.
  task automatic step(input string nm);
    exp_t e;
    logic [DW-1:0] d;
    bit pe;
    sb.push_back('{tag: $sformatf("%s.ready", nm), sel: 0, exp: {31'b0, m_run}});
    for (int k = 0; k < NRD; k++) begin
      exp_read(k, d, pe);
      sb.push_back('{tag: $sformatf("%s.rs%0d", nm, k), sel: 1+k, exp: d});
      sb.push_back('{tag: $sformatf("%s.perr%0d", nm, k), sel: 1+NRD+k, exp: {31'b0, pe}});
    end
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
    @(posedge clk);
    if (reset_i) begin
      m_run = 1'b0;
      m_ptr = 1;
    end else if (!m_run) begin
      m_mem[m_ptr] = '0;
      m_bad[m_ptr] = 1'b0;
      if (m_ptr == DEPTH-1) m_run = 1'b1;
      m_ptr++;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && wa[j*AW +: AW] != 0) begin
          m_mem[wa[j*AW +: AW]] = wd[j*DW +: DW];
          m_bad[wa[j*AW +: AW]] = 1'b0;
        end
      end
      if (clear_req_i) begin
        m_run = 1'b0;
        m_ptr = 1;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end
    m_run = 1'b0;
    m_ptr = 1;

    // 1: a single reset cycle, then idle through the clear (31 cycles of
    //    not-ready, then ready).
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    for (int c = 0; c < 32; c++) begin
      set_rd(0, c);
      set_rd(1, 31 - c);
      step($sformatf("clr%0d", c));
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(0, a);
      set_rd(1, a + 1);
      step("zero");
    end

    // 2: bypass, then a stored read.
    set_wr(0, 1'b1, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    set_rd(1, 5);
    step("byp5");
    no_wr();
    step("rd5");

    // 3: a write to x0 has no effect.
    set_wr(0, 1'b1, 0, 32'h1234);
    set_rd(0, 0);
    set_rd(1, 0);
    step("x0byp");
    no_wr();
    step("x0rd");

    // 4: write collision; the higher port wins.
    set_wr(0, 1'b1, 7, 32'h11);
    set_wr(1, 1'b1, 7, 32'h22);
    set_rd(0, 7);
    set_rd(1, 5);
    step("col7");
    no_wr();
    set_rd(1, 7);
    step("col7rd");

    // Mixed traffic.
    for (int n = 0; n < 40; n++) begin
      set_wr(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom);
      set_wr(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom);
      set_rd(0, int'($urandom_range(0, 31)));
      set_rd(1, (n % 4 == 0) ? int'(wa[AW +: AW]) : int'($urandom_range(0, 31)));
      step($sformatf("rnd%0d", n));
    end
    no_wr();

    // 5: a clear request, then a reset in the middle of the clear.
    set_wr(0, 1'b1, 3, 32'hA5);
    set_rd(0, 3);
    step("w3");
    no_wr();
    clear_req_i = 1'b1;
    step("creq");
    clear_req_i = 1'b0;
    for (int c = 1; c < 10; c++) step($sformatf("cl%0d", c));
    reset_i = 1'b1;
    step("rstmid");
    reset_i = 1'b0;
    for (int c = 0; c < 31; c++) step($sformatf("rclr%0d", c));
    set_rd(0, 3);
    set_rd(1, 7);
    step("after");

`ifdef TOAST_REGFILE_PARITY_EN
    // 6: a backdoor bit flip produces a parity error on array reads only.
    set_wr(0, 1'b1, 9, 32'h0F);
    step("w9");
    no_wr();
    dut.mem_q[9][4] = ~dut.mem_q[9][4];
    m_mem[9][4] = ~m_mem[9][4];
    m_bad[9] = 1'b1;
    set_rd(0, 9);
    set_rd(1, 9);
    step("par9");
    set_wr(1, 1'b1, 9, 32'h77);
    set_rd(1, 3);
    step("par9byp");
    no_wr();
    step("par9fix");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
